// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator sequencer.
//   FRAC_BITS / PERIOD : phase format (UQ16.FRAC_BITS Hz) and phase units per cycle
//   inc_t              : stored phase increment, 16+FRAC_BITS bits
//   phase_t            : phase with one extra carry bit for the modulo compare
//   osc_state_t        : sequencer FSM states
//   clamp_inc()        : limits an increment to one period minus one LSB
package osc_pkg;

  localparam int FRAC_BITS = 8;
  localparam int PERIOD    = 48000;
  localparam int INC_W     = 16 + FRAC_BITS;
  localparam int PHASE_W   = INC_W + 1;

  typedef logic [INC_W-1:0]   inc_t;
  typedef logic [PHASE_W-1:0] phase_t;

  // One full period in fixed-point phase units.
  localparam phase_t PERIOD_FX = phase_t'(PERIOD << FRAC_BITS);
  localparam inc_t   INC_MAX   = inc_t'((PERIOD << FRAC_BITS) - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ADVANCE,
    ST_OUTPUT
  } osc_state_t;

  function automatic inc_t clamp_inc(input inc_t d);
    return ({1'b0, d} >= PERIOD_FX) ? INC_MAX : d;
  endfunction

endpackage

// File: rtl/osc_phase_store.sv
// Per-voice increment and phase registers with the modulo-period adder.
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc_we      : write strobe; inc_data (clamped) goes to inc[inc_idx]
//   inc_idx     : voice written by inc_we
//   inc_data    : new increment, UQ16.FRAC_BITS
//   advance     : add inc[voice] to phase[voice], wrapping at one period
//   voice       : voice addressed by advance and by phase_int
//   phase_int   : integer part of phase[voice]
module osc_phase_store
  import osc_pkg::*;
#(
  parameter int VOICES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc_we,
  input  logic [$clog2(VOICES)-1:0] inc_idx,
  input  inc_t                      inc_data,
  input  logic                      advance,
  input  logic [$clog2(VOICES)-1:0] voice,
  output logic [15:0]               phase_int
);

  phase_t phase [VOICES];
  inc_t   inc   [VOICES];
  phase_t sum;
  phase_t wrapped;

  // Both operands are below one period, so a single conditional subtract wraps.
  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    sum     = phase[voice] + phase_t'(inc[voice]);
    wrapped = (sum >= PERIOD_FX) ? (sum - PERIOD_FX) : sum;
  end

  assign phase_int = phase[voice][INC_W-1:FRAC_BITS];

  // A write and an advance of the same voice in one cycle: the advance reads
  // the old increment because both update on the same edge.
  // NOTE: these small register arrays are reset (unlike RAMs) because voices must
  // start at phase 0 with a zero increment; <= keeps all reads pre-edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
      end
    end else begin
      if (inc_we) inc[inc_idx] <= clamp_inc(inc_data);
      if (advance) phase[voice] <= wrapped;
    end
  end

endmodule

// File: rtl/osc_sequencer.sv
// Walks VOICES oscillator phases once per sample tick through a shared
// waveform unit, sums the results and emits one scaled sample.
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : sample strobe; accepted only in IDLE
//   inc_we/idx/data : phase increment write port
//   wave_start   : one-cycle start to the waveform unit
//   wave_x       : integer phase for the waveform unit, held until next issue
//   wave_finish  : one-cycle finish, wave_y valid with it
//   wave_y       : signed 24-bit waveform result
//   sample_out   : signed mixed sample (sum >>> log2(VOICES))
//   sample_valid : one-cycle strobe for sample_out
//   busy         : frame in progress
//   overrun      : sticky, a tick arrived while busy
module osc_sequencer
  import osc_pkg::*;
#(
  parameter int VOICES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic                      inc_we,
  input  logic [$clog2(VOICES)-1:0] inc_idx,
  input  logic [16+FRAC_BITS-1:0]   inc_data,
  output logic                      wave_start,
  input  logic                      wave_finish,
  output logic [15:0]               wave_x,
  input  logic [23:0]               wave_y,
  output logic [23:0]               sample_out,
  output logic                      sample_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int VW    = $clog2(VOICES);
  localparam int ACC_W = 24 + VW;
  localparam logic [VW-1:0] LAST_VOICE = VW'(VOICES - 1);

  osc_state_t              state;
  osc_state_t              state_next;
  logic [VW-1:0]           voice;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_scaled;
  logic                    advance;
  logic [15:0]             phase_int;

  osc_phase_store #(.VOICES(VOICES)) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_we    (inc_we),
    .inc_idx   (inc_idx),
    .inc_data  (inc_data),
    .advance   (advance),
    .voice     (voice),
    .phase_int (phase_int)
  );

  // The sum of VOICES full-scale values always fits in ACC_W bits, so the
  // scaled result is a plain truncating arithmetic shift.
  assign acc_scaled = acc >>> VW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    unique case (state)
      ST_IDLE:    if (tick) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_WAIT;
      ST_WAIT:    if (wave_finish) state_next = ST_ADVANCE;
      ST_ADVANCE: begin
        advance    = 1'b1;
        state_next = (voice == LAST_VOICE) ? ST_OUTPUT : ST_ISSUE;
      end
      ST_OUTPUT:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // wave_start and sample_valid are registered: start is seen in the first
  // WAIT cycle together with the freshly loaded wave_x, and sample_valid is
  // high for exactly the OUTPUT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice        <= '0;
      acc          <= '0;
      wave_start   <= 1'b0;
      wave_x       <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      wave_start   <= (state == ST_ISSUE);
      sample_valid <= 1'b0;
      if (tick && (state != ST_IDLE)) overrun <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (tick) begin
            voice <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_ISSUE: wave_x <= phase_int;
        ST_WAIT: begin
          if (wave_finish) acc <= acc + {{VW{wave_y[23]}}, wave_y};
        end
        ST_ADVANCE: begin
          if (voice == LAST_VOICE) begin
            sample_out   <= acc_scaled[23:0];
            sample_valid <= 1'b1;
          end else begin
            voice <= voice + VW'(1);
          end
        end
        ST_OUTPUT: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_sequencer.sv
// Self-checking bench for osc_sequencer. A saw waveform unit with L=4 cycle
// latency answers each start; expected wave_x and sample values are queued
// when a frame is launched and a monitor compares them as the DUT emits them.
module tb_osc_sequencer;
  import osc_pkg::*;

  localparam int VOICES = 4;
  localparam int L      = 4;
  localparam int SAW_K  = 357912;        // saw slope, Q10: y = (x*SAW_K)>>10 mod 2^24
  localparam int PFX    = 48000 * 256;   // one period in phase units
  localparam int FRAME_LAT = VOICES * (3 + L) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        inc_we = 1'b0;
  logic [1:0]  inc_idx = '0;
  logic [23:0] inc_data = '0;
  logic        wave_start;
  logic        wave_finish = 1'b0;
  logic [15:0] wave_x;
  logic [23:0] wave_y = '0;
  logic [23:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int exp_x_q[$];
  int exp_s_q[$];
  int mdl_phase[VOICES];
  int mdl_inc[VOICES];
  int reset_epoch = 0;
  int last_sample = 0;

  always #5 clk = ~clk;

  osc_sequencer #(.VOICES(VOICES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .inc_we       (inc_we),
    .inc_idx      (inc_idx),
    .inc_data     (inc_data),
    .wave_start   (wave_start),
    .wave_finish  (wave_finish),
    .wave_x       (wave_x),
    .wave_y       (wave_y),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int saw(input int x);
    longint p;
    int v;
    p = (longint'(x) * SAW_K) >>> 10;
    v = int'(p & 64'hFFFFFF);
    if (v >= 32'h800000) v -= 32'h1000000;
    return v;
  endfunction

  // Waveform unit: finish L cycles after the start is seen.
  initial begin : saw_unit
    int x;
    int ep;
    forever begin
      @(negedge clk);
      if (rst_n && wave_start) begin
        x  = int'(wave_x);
        ep = reset_epoch;
        repeat (L) @(posedge clk);
        #1;
        if (ep == reset_epoch && rst_n) begin
          wave_y      = 24'(saw(x));
          wave_finish = 1'b1;
          @(posedge clk);
          #1;
          wave_finish = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (wave_start) begin
        if (exp_x_q.size() == 0) check("unexpected_wave_start", 1, 0);
        else check("wave_x", wave_x, exp_x_q.pop_front());
      end
      if (sample_valid) begin
        last_sample = $signed(sample_out);
        if (exp_s_q.size() == 0) check("unexpected_sample_valid", 1, 0);
        else check("sample_out", $signed(sample_out), exp_s_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void model_advance();
    for (int v = 0; v < VOICES; v++) begin
      mdl_phase[v] += mdl_inc[v];
      if (mdl_phase[v] >= PFX) mdl_phase[v] -= PFX;
    end
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < VOICES; v++) begin
      mdl_phase[v] = 0;
      mdl_inc[v]   = 0;
    end
  endfunction

  task automatic push_frame();
    int s;
    int x;
    s = 0;
    for (int v = 0; v < VOICES; v++) begin
      x = mdl_phase[v] >> 8;
      exp_x_q.push_back(x);
      s += saw(x);
    end
    exp_s_q.push_back(s >>> 2);
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic write_inc(input int idx, input int data);
    @(negedge clk);
    inc_we   = 1'b1;
    inc_idx  = 2'(idx);
    inc_data = 24'(data);
    @(negedge clk);
    inc_we   = 1'b0;
  endtask

  task automatic wait_sample(output int cyc);
    cyc = 1;
    while (!sample_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!sample_valid) begin
      check("frame_timeout", 0, 1);
      exp_x_q.delete();
      exp_s_q.delete();
    end
  endtask

  task automatic end_frame();
    model_advance();
    #1;
    check("queues_drained", exp_x_q.size() + exp_s_q.size(), 0);
  endtask

  task automatic run_frame(input bit chk_lat);
    int cyc;
    push_frame();
    pulse_tick();
    wait_sample(cyc);
    if (chk_lat) check("frame_latency", cyc, FRAME_LAT);
    end_frame();
  endtask

  initial begin : stimulus
    int cyc;
    int cnt;
    int starts;
    model_reset();

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_wave_start", wave_start, 0);
    check("rst_wave_x", wave_x, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Mix: voice 0 only, 12000 Hz. Second frame x=12000 -> 1048570.
    write_inc(0, 12000 << 8);
    mdl_inc[0] = 12000 * 256;
    run_frame(1'b1);
    push_frame();
    pulse_tick();
    check("busy_in_frame", busy, 1);
    wait_sample(cyc);
    end_frame();
    check("mix_sample", last_sample, 1048570);
    @(negedge clk);
    check("busy_after_frame", busy, 0);

    // Overrun: second tick 3 cycles after the first.
    check("overrun_before", overrun, 0);
    push_frame();
    pulse_tick();
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_sample(cyc);
    end_frame();
    check("overrun_set", overrun, 1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (sample_valid) cnt++;
    end
    check("overrun_single_sample", cnt, 0);
    check("overrun_sticky", overrun, 1);
    check("overrun_busy_clear", busy, 0);

    // Reset in the middle of WAIT.
    exp_x_q.push_back(mdl_phase[0] >> 8);
    pulse_tick();
    cnt = 0;
    while (!wave_start && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("reset_reached_wait", wave_start, 1);
    @(negedge clk);
    rst_n = 1'b0;
    reset_epoch++;
    #1;
    check("midrst_wave_start", wave_start, 0);
    check("midrst_wave_x", wave_x, 0);
    check("midrst_sample_out", sample_out, 0);
    check("midrst_sample_valid", sample_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    starts = 0;
    repeat (60) begin
      @(negedge clk);
      if (sample_valid) cnt++;
      if (wave_start) starts++;
    end
    check("post_reset_no_sample", cnt, 0);
    check("post_reset_no_start", starts, 0);
    #1;
    check("post_reset_queue", exp_x_q.size() + exp_s_q.size(), 0);

    // Wrap: voice 0 at 1000 Hz, x = 0,1000,...,47000,0,1000.
    write_inc(0, 1000 << 8);
    mdl_inc[0] = 1000 * 256;
    for (int k = 0; k < 50; k++) begin
      int x0;
      x0 = (1000 * k) % 48000;
      exp_x_q.push_back(x0);
      for (int v = 1; v < VOICES; v++) exp_x_q.push_back(0);
      exp_s_q.push_back(saw(x0) >>> 2);
      pulse_tick();
      wait_sample(cyc);
      end_frame();
    end

    // Clamp: 0xFFFFFF is stored as 0xBB7FFF.
    write_inc(0, 24'hFFFFFF);
    mdl_inc[0] = 24'hBB7FFF;
    repeat (3) run_frame(1'b0);
    // Half-hertz increment: x steps by 1 every 2 ticks.
    write_inc(0, 24'h000080);
    mdl_inc[0] = 24'h80;
    repeat (4) run_frame(1'b0);

    // Mid-frame writes during voice 1 WAIT.
    write_inc(1, 3000 << 8);
    mdl_inc[1] = 3000 * 256;
    run_frame(1'b0);
    push_frame();
    pulse_tick();
    starts = 0;
    cnt = 0;
    while (starts < 2 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (wave_start) starts++;
    end
    check("midwrite_voice1_start", starts, 2);
    inc_we   = 1'b1;
    inc_idx  = 2'd3;
    inc_data = 24'(5000 << 8);
    @(negedge clk);
    inc_idx  = 2'd0;
    inc_data = 24'(7000 << 8);
    @(negedge clk);
    inc_we   = 1'b0;
    wait_sample(cyc);
    mdl_inc[3] = 5000 * 256;   // voice 3 not yet advanced: new value applies now
    end_frame();
    mdl_inc[0] = 7000 * 256;   // voice 0 already advanced: applies next frame
    repeat (2) run_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
